alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised multi-cycle ALU for the LW datapath.
//   - Logic, add/sub and shift ops complete in one cycle.
//   - MUL/DIV are iterative: one bit per cycle, shift-add and restoring division.
//   - Valid/ready handshakes on both input and output, so it stalls with the datapath.
//   - Adds status flags and a high result word: MUL upper half, DIV remainder.
// PARAMETERS
//   M      32               operand/result width, >= 4
//   CNT_W  $clog2(M+1)      iteration counter width (derived, do not override)
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   operands/opcode valid
//   in_ready   out  1   block can accept an operation
//   A, B       in   M   operands, unsigned
//   ALU_Sel    in   4   opcode (alu_op_e)
//   out_valid  out  1   result valid, held until out_ready
//   out_ready  in   1   consumer accepts result
//   ALU_Out    out  M   result (low word / quotient)
//   ALU_Hi     out  M   MUL high word / DIV remainder, 0 for other ops
//   flags      out  4   {zero, carry, ovf, dbz}
// BEHAVIOUR
//   Opcodes
//     0000 ADD   0001 SUB   0010 MUL   0011 DIV
//     0100 SLL by B[CNT_W-2:0]   0101 SRL by B[CNT_W-2:0]
//     0110 AND   0111 OR   1000 XOR   1001 NOR   1010 NAND   1011 XNOR
//     1100-1111: treated as ADD, identical results and flags.
//   Shift amount is taken mod M; shifts are logical and zero-fill.
//   FSM states IDLE, BUSY, DONE.
//     - in_ready = (state==IDLE); inputs are ignored otherwise.
//     - IDLE: on in_valid, latch A, B, opcode.
//       * Single-cycle op or DIV with B==0 -> DONE.
//       * MUL/DIV -> BUSY, cnt=M.
//     - BUSY: one iteration per cycle, cnt--; at cnt==1 the final step completes -> DONE.
//     - DONE: out_valid=1; outputs stable until out_ready.
//       * out_ready -> IDLE.
//       * No same-cycle re-accept: throughput is 1 op per 2 cycles minimum.
//   Latency, for acceptance at edge t:
//     - simple op: out_valid is high in the cycle after edge t.
//     - MUL/DIV: out_valid is high after edge t+M.
//   Arithmetic
//     ADD  {carry,Out} = A+B; ovf = signed overflow (A[M-1]==B[M-1] && Out[M-1]!=A[M-1]).
//     SUB  Out = A-B; carry = borrow (A<B); ovf = signed overflow of A-B.
//     MUL  {Hi,Out} = A*B (2M bits); carry = ovf = (Hi!=0).
//     DIV  Out = A/B, Hi = A%B.
//     DIV by zero: Out = all-ones, Hi = A, dbz=1, single-cycle path.
//     Logic ops and shifts: carry = ovf = 0, Hi = 0.
//     zero = (Out==0) for every op. dbz = 0 except DIV by zero.
//   Reset values
//     state=IDLE, in_ready=1 from the cycle after reset.
//     out_valid=0, ALU_Out=0, ALU_Hi=0, flags=0.
//   Reset mid-operation (BUSY or DONE): abort with no output. Partial results are discarded.
//   Operands change while BUSY: no effect, latched copies are used.
//   out_ready while not DONE: ignored.
// STRUCTURE
//   alu_pkg
//     typedef enum logic [3:0] alu_op_e (ADD..XNOR).
//     typedef enum logic [1:0] alu_state_e {IDLE, BUSY, DONE}.
//     Flag bit index localparams: FLG_ZERO=3, FLG_CARRY=2, FLG_OVF=1, FLG_DBZ=0.
//   Sub-module alu_muldiv_iter #(M)
//     Interface: start, is_div, a, b -> busy, done, lo, hi.
//     Holds the accumulator/remainder shift registers and cnt.
//   Top level: FSM, single-cycle combinational ops, output/flag registers.
// TESTING  (M=8 unless noted)
//   1. ADD A=8'hFF B=8'h01 -> Out=8'h00, flags zero=1 carry=1 ovf=0 dbz=0,
//      out_valid one cycle after accept.
//      ADD A=8'h7F B=8'h01 -> Out=8'h80, ovf=1.
//   2. MUL A=8'd200 B=8'd3 -> Out=8'h58, Hi=8'h02, carry=ovf=1,
//      out_valid exactly 8 cycles after accept; in_ready=0 throughout.
//   3. DIV A=8'd100 B=8'd7 -> Out=8'd14, Hi=8'd2, 8-cycle latency.
//      DIV A=8'd5 B=0 -> Out=8'hFF, Hi=8'd5, dbz=1, 1-cycle latency.
//   4. Backpressure: out_ready=0 for 5 cycles after a SUB A=3 B=5 result ->
//      Out=8'hFE, carry=1 held stable; in_valid pulses meanwhile are not accepted.
//   5. rst asserted at BUSY cycle 4 of a MUL -> next cycle state=IDLE,
//      out_valid=0, outputs 0; a following AND A=8'hF0 B=8'h3C gives 8'h30.
//   6. SLL A=8'h81 B=8'd9 -> Out=8'h02 (shift mod 8).
//      Opcode 4'b1110 with A=2 B=3 -> Out=5 (default ADD).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU: opcodes, FSM states and
// the bit layout of the status flag word.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_DIV  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_AND  = 4'b0110,
    OP_OR   = 4'b0111,
    OP_XOR  = 4'b1000,
    OP_NOR  = 4'b1001,
    OP_NAND = 4'b1010,
    OP_XNOR = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam int FLG_ZERO  = 3;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 1;
  localparam int FLG_DBZ   = 0;

  function automatic logic [3:0] packFlags(input logic zero, input logic carry,
                                           input logic ovf, input logic dbz);
    logic [3:0] f;
    f            = '0;
    f[FLG_ZERO]  = zero;
    f[FLG_CARRY] = carry;
    f[FLG_OVF]   = ovf;
    f[FLG_DBZ]   = dbz;
    return f;
  endfunction

  // Two's-complement overflow from sign bits only; subtraction flips the
  // "operands agree" test because B is effectively negated.
  function automatic logic signedOvf(input logic aMsb, input logic bMsb,
                                     input logic rMsb, input logic isSub);
    logic signsMatch;
    signsMatch = isSub ? (aMsb != bMsb) : (aMsb == bMsb);
    return signsMatch && (rMsb != aMsb);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiplier / restoring divider sharing one {hi, lo} shift pair.
// MUL: hi accumulates the upper product, lo shifts out multiplier bits.
// DIV: hi holds the partial remainder, lo shifts dividend in / quotient out.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int M     = 32,
  parameter int CNT_W = $clog2(M + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] lo,
  output logic [M-1:0] hi
);

  logic [M-1:0]     r_hi;
  logic [M-1:0]     r_lo;
  logic [M-1:0]     r_b;
  logic             r_isDiv;
  logic [CNT_W-1:0] r_cnt;

  logic [M:0]       w_mulSum;
  logic [M:0]       w_divShift;
  logic [M:0]       w_divTrial;
  logic [M-1:0]     w_stepHi;
  logic [M-1:0]     w_stepLo;

  // One iteration of the selected algorithm, computed from the current regs.
  always_comb begin
    w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_divShift = {r_hi, r_lo[M-1]};
    w_divTrial = w_divShift - {1'b0, r_b};
    w_stepHi   = w_mulSum[M:1];
    w_stepLo   = {w_mulSum[0], r_lo[M-1:1]};
    if (r_isDiv) begin
      if (!w_divTrial[M]) begin
        w_stepHi = w_divTrial[M-1:0];
        w_stepLo = {r_lo[M-2:0], 1'b1};
      end else begin
        w_stepHi = w_divShift[M-1:0];
        w_stepLo = {r_lo[M-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_isDiv <= 1'b0;
      r_cnt   <= '0;
    end else if (start) begin
      r_hi    <= '0;
      r_lo    <= a;
      r_b     <= b;
      r_isDiv <= is_div;
      r_cnt   <= CNT_W'(M);
    end else if (r_cnt != '0) begin
      r_hi    <= w_stepHi;
      r_lo    <= w_stepLo;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  // lo/hi present the post-step value so the final result can be captured
  // on the same edge that performs the last iteration.
  assign busy = (r_cnt != '0);
  assign done = (r_cnt == CNT_W'(1));
  assign lo   = w_stepLo;
  assign hi   = w_stepHi;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/add/shift,
// iterative MUL/DIV, registered result, high word and status flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int M     = 32,
  parameter int CNT_W = $clog2(M + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic [3:0]   ALU_Sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] ALU_Out,
  output logic [M-1:0] ALU_Hi,
  output logic [3:0]   flags
);

  alu_state_e     r_state;
  alu_state_e     w_nextState;

  logic [M-1:0]   r_out;
  logic [M-1:0]   r_hi;
  logic [3:0]     r_flags;
  logic           r_isDiv;

  logic           w_accept;
  logic           w_isDiv;
  logic           w_isMulDiv;
  logic           w_divZero;
  logic           w_start;
  logic           w_iterBusy;
  logic           w_iterDone;
  logic [M-1:0]   w_iterLo;
  logic [M-1:0]   w_iterHi;

  logic [M:0]     w_sum;
  logic [M:0]     w_diff;
  logic [CNT_W-2:0] w_shamt;
  logic [M-1:0]   w_simpleOut;
  logic           w_simpleCarry;
  logic           w_simpleOvf;

  assign w_isDiv    = (ALU_Sel == OP_DIV);
  assign w_isMulDiv = (ALU_Sel == OP_MUL) || w_isDiv;
  assign w_divZero  = w_isDiv && (B == '0);
  assign in_ready   = (r_state == IDLE) && !w_iterBusy;
  assign w_accept   = in_ready && in_valid;
  assign w_shamt    = B[CNT_W-2:0];

  alu_muldiv_iter #(
    .M     (M),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .is_div (w_isDiv),
    .a      (A),
    .b      (B),
    .busy   (w_iterBusy),
    .done   (w_iterDone),
    .lo     (w_iterLo),
    .hi     (w_iterHi)
  );

  // Single-cycle datapath; unlisted opcodes (incl. 1100-1111) behave as ADD.
  always_comb begin
    w_sum         = {1'b0, A} + {1'b0, B};
    w_diff        = {1'b0, A} - {1'b0, B};
    w_simpleOut   = w_sum[M-1:0];
    w_simpleCarry = w_sum[M];
    w_simpleOvf   = signedOvf(A[M-1], B[M-1], w_sum[M-1], 1'b0);
    case (ALU_Sel)
      OP_SUB: begin
        w_simpleOut   = w_diff[M-1:0];
        w_simpleCarry = w_diff[M];
        w_simpleOvf   = signedOvf(A[M-1], B[M-1], w_diff[M-1], 1'b1);
      end
      OP_SLL:  begin w_simpleOut = A << w_shamt;  w_simpleCarry = 1'b0; w_simpleOvf = 1'b0; end
      OP_SRL:  begin w_simpleOut = A >> w_shamt;  w_simpleCarry = 1'b0; w_simpleOvf = 1'b0; end
      OP_AND:  begin w_simpleOut = A & B;         w_simpleCarry = 1'b0; w_simpleOvf = 1'b0; end
      OP_OR:   begin w_simpleOut = A | B;         w_simpleCarry = 1'b0; w_simpleOvf = 1'b0; end
      OP_XOR:  begin w_simpleOut = A ^ B;         w_simpleCarry = 1'b0; w_simpleOvf = 1'b0; end
      OP_NOR:  begin w_simpleOut = ~(A | B);      w_simpleCarry = 1'b0; w_simpleOvf = 1'b0; end
      OP_NAND: begin w_simpleOut = ~(A & B);      w_simpleCarry = 1'b0; w_simpleOvf = 1'b0; end
      OP_XNOR: begin w_simpleOut = ~(A ^ B);      w_simpleCarry = 1'b0; w_simpleOvf = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_isMulDiv && !w_divZero) begin
            w_start     = 1'b1;
            w_nextState = BUSY;
          end else begin
            w_nextState = DONE;
          end
        end
      end
      BUSY:    if (w_iterDone) w_nextState = DONE;
      DONE:    if (out_ready)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Result registers load on acceptance (single-cycle ops, DIV by zero) or
  // on the final MUL/DIV iteration, then hold through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_hi    <= '0;
      r_flags <= '0;
      r_isDiv <= 1'b0;
    end else if (w_accept) begin
      r_isDiv <= w_isDiv;
      if (w_divZero) begin
        r_out   <= '1;
        r_hi    <= A;
        r_flags <= packFlags(1'b0, 1'b0, 1'b0, 1'b1);
      end else if (!w_isMulDiv) begin
        r_out   <= w_simpleOut;
        r_hi    <= '0;
        r_flags <= packFlags(w_simpleOut == '0, w_simpleCarry, w_simpleOvf, 1'b0);
      end
    end else if ((r_state == BUSY) && w_iterDone) begin
      r_out   <= w_iterLo;
      r_hi    <= w_iterHi;
      r_flags <= packFlags(w_iterLo == '0,
                           !r_isDiv && (w_iterHi != '0),
                           !r_isDiv && (w_iterHi != '0),
                           1'b0);
    end
  end

  assign out_valid = (r_state == DONE);
  assign ALU_Out   = r_out;
  assign ALU_Hi    = r_hi;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at M=8: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_seq;

  localparam int M = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic [3:0]   ALU_Sel;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] ALU_Out;
  logic [M-1:0] ALU_Hi;
  logic [3:0]   flags;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  alu_seq #(.M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_Out   (ALU_Out),
    .ALU_Hi    (ALU_Hi),
    .flags     (flags)
  );

  // Reference model: integer arithmetic straight from the opcode table.
  function automatic void refModel(input logic [3:0] op, input logic [7:0] a,
                                   input logic [7:0] b, output logic [7:0] expOut,
                                   output logic [7:0] expHi, output logic [3:0] expFlags);
    int ua, ub, sa, sb, r;
    logic c, v, d;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0; d = 1'b0;
    expHi = 8'h00;
    case (op)
      4'd1: begin
        r = ua - ub; expOut = 8'(r); c = (ua < ub);
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      4'd2: begin
        r = ua * ub; expOut = 8'(r); expHi = 8'(r / 256);
        c = (expHi != 8'h00); v = c;
      end
      4'd3: begin
        if (ub == 0) begin expOut = 8'hFF; expHi = a; d = 1'b1; end
        else begin expOut = 8'(ua / ub); expHi = 8'(ua % ub); end
      end
      4'd4:  expOut = 8'(ua << (ub % 8));
      4'd5:  expOut = 8'(ua >> (ub % 8));
      4'd6:  expOut = a & b;
      4'd7:  expOut = a | b;
      4'd8:  expOut = a ^ b;
      4'd9:  expOut = ~(a | b);
      4'd10: expOut = ~(a & b);
      4'd11: expOut = ~(a ^ b);
      default: begin
        r = ua + ub; expOut = 8'(r); c = (r > 255);
        v = (sa + sb > 127) || (sa + sb < -128);
      end
    endcase
    expFlags = {expOut == 8'h00, c, v, d};
  endfunction

  // Drives one operation, then counts edges after acceptance until out_valid.
  // Operands are scrambled while waiting to show the DUT uses latched copies.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a,
                               input logic [7:0] b, output int edges,
                               output logic readyLow);
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    ALU_Sel  = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges    = 0;
    readyLow = 1'b1;
    while (!out_valid && edges < 40) begin
      if (in_ready) readyLow = 1'b0;
      A       = 8'($urandom);
      B       = 8'($urandom);
      ALU_Sel = 4'($urandom);
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALU_Sel = '0;
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if ({out_valid, ALU_Out, ALU_Hi, flags} !== 21'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got valid=%b out=%h hi=%h flags=%b, expected all 0",
               out_valid, ALU_Out, ALU_Hi, flags);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    testsRun++;
    if ({in_ready, out_valid} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_add();
    int edges; logic rl;
    applyStimulus(4'd0, 8'hFF, 8'h01, edges, rl);
    testsRun++;
    if ({ALU_Out, ALU_Hi, flags} !== {8'h00, 8'h00, 4'b1100}) begin
      testsFailed++;
      $display("[TB] FAIL add_carry: got %h/%h/%b, expected 00/00/1100", ALU_Out, ALU_Hi, flags);
    end
    testsRun++;
    if (edges !== 0) begin
      testsFailed++;
      $display("[TB] FAIL add_latency: got %0d extra edges, expected 0", edges);
    end
    releaseResult();
    applyStimulus(4'd0, 8'h7F, 8'h01, edges, rl);
    testsRun++;
    if ({ALU_Out, ALU_Hi, flags} !== {8'h80, 8'h00, 4'b0010}) begin
      testsFailed++;
      $display("[TB] FAIL add_ovf: got %h/%h/%b, expected 80/00/0010", ALU_Out, ALU_Hi, flags);
    end
    releaseResult();
  endtask

  task automatic test_mul();
    int edges; logic rl;
    applyStimulus(4'd2, 8'd200, 8'd3, edges, rl);
    testsRun++;
    if ({ALU_Out, ALU_Hi, flags} !== {8'h58, 8'h02, 4'b0110}) begin
      testsFailed++;
      $display("[TB] FAIL mul_result: got %h/%h/%b, expected 58/02/0110", ALU_Out, ALU_Hi, flags);
    end
    testsRun++;
    if (edges !== 8) begin
      testsFailed++;
      $display("[TB] FAIL mul_latency: got %0d edges, expected 8", edges);
    end
    testsRun++;
    if (rl !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL mul_in_ready: got in_ready high while busy, expected low");
    end
    releaseResult();
  endtask

  task automatic test_div();
    int edges; logic rl;
    applyStimulus(4'd3, 8'd100, 8'd7, edges, rl);
    testsRun++;
    if ({ALU_Out, ALU_Hi, flags, edges} !== {8'd14, 8'd2, 4'b0000, 32'd8}) begin
      testsFailed++;
      $display("[TB] FAIL div_result: got %0d/%0d/%b edges=%0d, expected 14/2/0000 edges=8",
               ALU_Out, ALU_Hi, flags, edges);
    end
    releaseResult();
    applyStimulus(4'd3, 8'd5, 8'd0, edges, rl);
    testsRun++;
    if ({ALU_Out, ALU_Hi, flags, edges} !== {8'hFF, 8'd5, 4'b0001, 32'd0}) begin
      testsFailed++;
      $display("[TB] FAIL div_by_zero: got %h/%h/%b edges=%0d, expected FF/05/0001 edges=0",
               ALU_Out, ALU_Hi, flags, edges);
    end
    releaseResult();
  endtask

  task automatic test_backpressure();
    int edges; logic rl;
    applyStimulus(4'd1, 8'd3, 8'd5, edges, rl);
    testsRun++;
    if ({ALU_Out, ALU_Hi, flags, edges} !== {8'hFE, 8'h00, 4'b0100, 32'd0}) begin
      testsFailed++;
      $display("[TB] FAIL sub_borrow: got %h/%h/%b edges=%0d, expected FE/00/0100 edges=0",
               ALU_Out, ALU_Hi, flags, edges);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; ALU_Sel = 4'd0; A = 8'h01; B = 8'h01;
      @(posedge clk); #1;
      testsRun++;
      if ({out_valid, in_ready, ALU_Out, ALU_Hi, flags} !== {1'b1, 1'b0, 8'hFE, 8'h00, 4'b0100}) begin
        testsFailed++;
        $display("[TB] FAIL hold_cycle%0d: got valid=%b ready=%b %h/%h/%b, expected 1/0 FE/00/0100",
                 i, out_valid, in_ready, ALU_Out, ALU_Hi, flags);
      end
    end
    in_valid = 1'b0;
    releaseResult();
    testsRun++;
    if ({in_ready, out_valid} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL release_idle: got ready=%b valid=%b, expected 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    testsRun++;
    if (out_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL no_stale_accept: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int edges; logic rl; logic sawValid;
    ALU_Sel = 4'd2; A = 8'd200; B = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    testsRun++;
    if ({in_ready, out_valid, ALU_Out, ALU_Hi, flags} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid: got ready=%b valid=%b %h/%h/%b, expected 1/0 00/00/0000",
               in_ready, out_valid, ALU_Out, ALU_Hi, flags);
    end
    sawValid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    testsRun++;
    if (sawValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_abort: got out_valid after abort, expected none");
    end
    applyStimulus(4'd6, 8'hF0, 8'h3C, edges, rl);
    testsRun++;
    if ({ALU_Out, ALU_Hi, flags, edges} !== {8'h30, 8'h00, 4'b0000, 32'd0}) begin
      testsFailed++;
      $display("[TB] FAIL and_after_reset: got %h/%h/%b edges=%0d, expected 30/00/0000 edges=0",
               ALU_Out, ALU_Hi, flags, edges);
    end
    releaseResult();
  endtask

  task automatic test_shift_default();
    int edges; logic rl;
    applyStimulus(4'd4, 8'h81, 8'd9, edges, rl);
    testsRun++;
    if ({ALU_Out, ALU_Hi, flags} !== {8'h02, 8'h00, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL sll_mod: got %h/%h/%b, expected 02/00/0000", ALU_Out, ALU_Hi, flags);
    end
    releaseResult();
    applyStimulus(4'b1110, 8'd2, 8'd3, edges, rl);
    testsRun++;
    if ({ALU_Out, ALU_Hi, flags} !== {8'd5, 8'h00, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL default_add: got %h/%h/%b, expected 05/00/0000", ALU_Out, ALU_Hi, flags);
    end
    releaseResult();
  endtask

  task automatic test_random();
    int edges, expEdges;
    logic rl;
    logic [3:0] op;
    logic [7:0] a, b, expOut, expHi;
    logic [3:0] expFlags;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      refModel(op, a, b, expOut, expHi, expFlags);
      expEdges = ((op == 4'd2) || ((op == 4'd3) && (b != 8'h00))) ? M : 0;
      applyStimulus(op, a, b, edges, rl);
      testsRun++;
      if ({ALU_Out, ALU_Hi, flags} !== {expOut, expHi, expFlags}) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d op=%h a=%h b=%h: got %h/%h/%b, expected %h/%h/%b",
                 n, op, a, b, ALU_Out, ALU_Hi, flags, expOut, expHi, expFlags);
      end
      testsRun++;
      if (edges !== expEdges) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_latency op=%h: got %0d edges, expected %0d", n, op, edges, expEdges);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      releaseResult();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid();
    test_shift_default();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
